iecdrv_rom_share: RTL and testbench
===================================

Name: iecdrv_rom_share

Overview:
- Parametrised time-sliced read arbiter that lets up to 8 IEC drive cores share one synchronous ROM within each CPU phase window.
- Generalises the fixed 4-slot, 1-cycle-latency scheme in three ways:
  - configurable port count, widths and ROM read latency;
  - disabled ports are skipped, so their slots are not spent;
  - window overrun is detected and flagged.
- Sits between the drive cores' rom_addr/rom_data ports and the shared ROM instance, in the drive clock domain.

Parameters:
- NPORT, 4, number of requesting drives (1..8)
- AW, 15, ROM address width
- DW, 8, ROM data width
- RD_LAT, 1, ROM read latency in clk cycles from mem_addr to mem_q valid (1..3)

Ports:
- clk  in  1  drive clock (16 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  window start pulse (ph2_f)
- port_en  in  NPORT  per-port enable; disabled ports are skipped
- port_addr  in  NPORT*AW  per-port ROM address, packed, port 0 in LSBs
- port_data  out  NPORT*DW  per-port returned ROM data, packed
- port_vld  out  NPORT  1-cycle pulse when a port's port_data updates
- mem_addr  out  AW  shared ROM address (registered)
- mem_q  in  DW  shared ROM read data
- busy  out  1  window in progress
- done  out  1  1-cycle pulse when the window completes
- overrun  out  1  sticky; set when start arrives while busy

Behaviour:
- Reset (async, reset_n=0) values:
  - mem_addr, port_data, port_vld, busy, done, overrun all 0.
  - Scheduler returns to IDLE; the capture pipeline is flushed.
- FSM states: IDLE, ISSUE, DRAIN.
- start sampled at cycle t:
  - Snapshot port_en into en_q and every port_addr into addr_q. Later changes to either input do not affect this window.
  - K = popcount(en_q).
  - If K=0: done pulses at t+1, busy stays 0, state stays IDLE.
  - Else: state goes to ISSUE, busy=1 from t+1.
- ISSUE:
  - Each cycle, mem_addr <= addr_q of the lowest-index enabled port not yet issued.
  - That port's index enters a delay line RD_LAT deep, as a tag.
  - After the K-th issue, state goes to DRAIN.
- Capture:
  - When a tag exits the delay line, mem_q is registered into that port's port_data slice.
  - port_vld for that port pulses in the same cycle the slice updates.
- First issue: mem_addr presents at t+1. The i-th enabled port (i=0..K-1) has port_data visible at t+2+RD_LAT+i.
- DRAIN:
  - Lasts until the last tag captures.
  - done pulses in the same cycle the last port_data becomes visible (t+1+RD_LAT+K).
  - busy falls to 0 in the same cycle, then state goes to IDLE.
- Disabled ports hold their previous port_data indefinitely and never pulse port_vld.
- start while busy:
  - overrun <= 1. It is sticky and clears only on reset.
  - A new snapshot is taken and issuing restarts from the lowest enabled port.
  - Tags already in the delay line still complete their captures into their own ports.
  - done pulses once, for the restarted window only.
- start in the same cycle as done: treated as a fresh window with no overrun. done still pulses.
- mem_addr holds its last value when no issue occurs.
- Tag width is clog2(NPORT), minimum 1.

Optional Feature:
- IECDRV_ROMSHARE_WR_EN: adds a ROM load port on the same clock.
  - Adds inputs wr_en (1), wr_addr (AW), wr_data (DW) and outputs mem_we (1), mem_wdata (DW).
- With the macro defined:
  - A cycle with wr_en=1 drives mem_addr=wr_addr, mem_wdata=wr_data and mem_we=1 (registered).
  - Read issue stalls that cycle and all later completion times shift by 1.
  - Writes take priority over reads.
- Without the macro: those ports are absent and the block is read-only.

Decomposition:
- Package iecdrv_rom_share_pkg holds:
  - MAX_PORT=8, MAX_RD_LAT=3;
  - typedef port_idx_t (logic [2:0]);
  - state enum {IDLE, ISSUE, DRAIN}.
- Sub-module iecdrv_rom_share_pipe: RD_LAT-deep valid+tag delay line with async reset. It is reused for the capture path.

Test Plan:
- NPORT=4, RD_LAT=1, port_en=4'hF, addresses 0x0000/0x1000/0x2000/0x3000, ROM[a]=a[15:8] XOR 0x5A; start at t -> port_data = 5A,4A,7A,6A, visible at t+3..t+6; done at t+6.
- port_en=4'b1010 -> only ports 1 and 3 update, at t+3 and t+4; done at t+4; ports 0 and 2 hold their prior values.
- port_en=0, start -> done at t+1, busy never asserted, no port_vld.
- start again 2 cycles into a window -> overrun=1; the in-flight tag captures correctly; the restarted window completes with all 4 ports updated; exactly one done.
- Assert reset_n low mid-ISSUE -> all outputs 0 immediately; a subsequent start completes normally with overrun=0.
- With IECDRV_ROMSHARE_WR_EN: wr_en at t+2 -> mem_we pulse, wr_data readable by the next window, completion delayed 1 cycle (done at t+7).

Source files
------------

// File: rtl/iecdrv_rom_share_pkg.sv
// Shared constants, types and helpers for the iecdrv_rom_share ROM arbiter.
package iecdrv_rom_share_pkg;

  localparam int MAX_PORT   = 8;
  localparam int MAX_RD_LAT = 3;
  localparam int EPOCH_W    = 3;

  typedef logic [2:0] port_idx_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  function automatic port_idx_t lowest_idx(input logic [MAX_PORT-1:0] m);
    port_idx_t r;
    r = '0;
    for (int i = MAX_PORT - 1; i >= 0; i--)
      if (m[i]) r = port_idx_t'(i);
    return r;
  endfunction

endpackage

// File: rtl/iecdrv_rom_share_pipe.sv
// Valid+tag delay line matching the shared ROM read latency; feeds the capture path.
module iecdrv_rom_share_pipe
  import iecdrv_rom_share_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [TW-1:0] push_tag,
  output logic          pop,
  output logic [TW-1:0] pop_tag
);

  localparam int D = (DEPTH < 1) ? 1 : ((DEPTH > MAX_RD_LAT) ? MAX_RD_LAT : DEPTH);

  logic [D-1:0]  vld_p;
  logic [TW-1:0] tag_p [D];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
      for (int i = 0; i < D; i++) tag_p[i] <= '0;
    end else begin
      vld_p[0] <= push;
      tag_p[0] <= push_tag;
      for (int i = 1; i < D; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign pop     = vld_p[D-1];
  assign pop_tag = tag_p[D-1];

endmodule

// File: rtl/iecdrv_rom_share.sv
// Time-sliced shared-ROM read arbiter for up to 8 IEC drive cores.
// Optional ROM load port enabled by defining IECDRV_ROMSHARE_WR_EN.
module iecdrv_rom_share
  import iecdrv_rom_share_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int AW     = 15,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NPORT-1:0]    port_en,
  input  logic [NPORT*AW-1:0] port_addr,
  output logic [NPORT*DW-1:0] port_data,
  output logic [NPORT-1:0]    port_vld,
  output logic [AW-1:0]       mem_addr,
  input  logic [DW-1:0]       mem_q,
`ifdef IECDRV_ROMSHARE_WR_EN
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic                mem_we,
  output logic [DW-1:0]       mem_wdata,
`endif
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
  // Tag = {window epoch, last-of-window, port index}; the epoch keeps tags
  // from a superseded window from completing the current one.
  localparam int TW = EPOCH_W + 1 + IW;

  state_t              state;
  logic [NPORT-1:0]    rem_q;
  logic [NPORT*AW-1:0] addr_q;
  logic [EPOCH_W-1:0]  epoch;
  logic [EPOCH_W-1:0]  epoch_nxt;
  logic                iss_vld_p0;
  logic [TW-1:0]       iss_tag_p0;
  logic                cap_vld;
  logic [TW-1:0]       cap_tag;
  logic [IW-1:0]       cap_idx;
  logic                cap_last;
  logic [EPOCH_W-1:0]  cap_epoch;

  logic [NPORT-1:0]    src_rem;
  logic [NPORT-1:0]    rem_next;
  logic [NPORT*AW-1:0] src_addr;
  logic [AW-1:0]       sel_addr;
  port_idx_t           sel;
  logic                want;
  logic                stall;
  logic                do_issue;
  logic                last;

`ifdef IECDRV_ROMSHARE_WR_EN
  assign stall = wr_en;
`else
  assign stall = 1'b0;
`endif

  // A start pulse issues its first read in the same cycle straight from the inputs.
  always_comb begin
    src_rem   = start ? port_en : rem_q;
    src_addr  = start ? port_addr : addr_q;
    want      = start ? (port_en != '0) : (state == ISSUE);
    do_issue  = want && !stall;
    sel       = lowest_idx(MAX_PORT'(src_rem));
    sel_addr  = src_addr[int'(sel)*AW +: AW];
    rem_next  = src_rem & ~(NPORT'(1) << sel);
    last      = (rem_next == '0);
    epoch_nxt = start ? epoch + EPOCH_W'(1) : epoch;
  end

  assign {cap_epoch, cap_last, cap_idx} = cap_tag;

  // Stage p0: scheduler and registered ROM address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rem_q      <= '0;
      addr_q     <= '0;
      epoch      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      iss_vld_p0 <= 1'b0;
      iss_tag_p0 <= '0;
      mem_addr   <= '0;
`ifdef IECDRV_ROMSHARE_WR_EN
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
`endif
    end else begin
      done       <= 1'b0;
      iss_vld_p0 <= do_issue;
      if (do_issue) begin
        mem_addr   <= sel_addr;
        iss_tag_p0 <= {epoch_nxt, last, sel[IW-1:0]};
      end
`ifdef IECDRV_ROMSHARE_WR_EN
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
`endif
      if (start) begin
        if (busy) overrun <= 1'b1;
        epoch  <= epoch_nxt;
        addr_q <= port_addr;
        rem_q  <= do_issue ? rem_next : port_en;
        if (port_en == '0) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          busy  <= 1'b1;
          state <= (do_issue && last) ? DRAIN : ISSUE;
        end
      end else begin
        case (state)
          ISSUE: if (do_issue) begin
            rem_q <= rem_next;
            if (last) state <= DRAIN;
          end
          DRAIN: if (cap_vld && cap_last && (cap_epoch == epoch)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  iecdrv_rom_share_pipe #(
    .DEPTH (RD_LAT),
    .TW    (TW)
  ) u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (iss_vld_p0),
    .push_tag (iss_tag_p0),
    .pop      (cap_vld),
    .pop_tag  (cap_tag)
  );

  // Stage p1+RD_LAT: capture ROM data into the tagged port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_data <= '0;
      port_vld  <= '0;
    end else begin
      port_vld <= '0;
      if (cap_vld) begin
        port_data[int'(cap_idx)*DW +: DW] <= mem_q;
        port_vld <= NPORT'(1) << cap_idx;
      end
    end
  end

endmodule

// File: tb/tb_iecdrv_rom_share.sv
// Self-checking bench for iecdrv_rom_share: vector table, corner sequences, random windows.
module tb_iecdrv_rom_share;

  localparam int NP = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic reset_n, start;
  logic [NP-1:0] port_en;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_data;
  logic [NP-1:0] port_vld;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_q = '0;
  logic busy, done, overrun;
`ifdef IECDRV_ROMSHARE_WR_EN
  logic wr_en, mem_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, mem_wdata;
  logic [7:0] wmem [logic [15:0]];
`endif

  iecdrv_rom_share #(.NPORT(NP), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .port_en(port_en),
    .port_addr(port_addr), .port_data(port_data), .port_vld(port_vld),
    .mem_addr(mem_addr), .mem_q(mem_q),
`ifdef IECDRV_ROMSHARE_WR_EN
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
`endif
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    return a[15:8] ^ 8'h5A;
  endfunction

  // One-cycle synchronous ROM
  always @(posedge clk) begin
`ifdef IECDRV_ROMSHARE_WR_EN
    if (wmem.exists(mem_addr)) mem_q <= wmem[mem_addr];
    else mem_q <= rom_fn(mem_addr);
    if (mem_we) wmem[mem_addr] <= mem_wdata;
`else
    mem_q <= rom_fn(mem_addr);
`endif
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: per-cycle predictions derived from the window timing rules.
  logic [3:0]  m_vld  [int];
  logic [31:0] m_pd   [int];
  bit          m_done [int];
  bit          m_busy [int];
  bit          m_aval [int];
  logic [15:0] m_addr [int];
  int          m_ov_cyc;
  logic [31:0] ref_pd;
  bit          mon_on;

  function automatic bit busy_at(input int c);
    return m_busy.exists(c) ? m_busy[c] : 1'b0;
  endfunction

  task automatic model_reset();
    m_vld.delete(); m_pd.delete(); m_done.delete();
    m_busy.delete(); m_aval.delete(); m_addr.delete();
    m_ov_cyc = 1 << 30;
    ref_pd = '0;
  endtask

  task automatic model_start(input int ts, input logic [3:0] en, input logic [63:0] addrs);
    int ks[$];
    int k, c;
    logic [15:0] a;
    logic [31:0] pd;
    if (busy_at(ts) && m_ov_cyc > ts + 1) m_ov_cyc = ts + 1;
    foreach (m_done[i]) if (i > ts) m_done[i] = 1'b0;
    foreach (m_busy[i]) if (i > ts) m_busy[i] = 1'b0;
    foreach (m_aval[i]) if (i > ts) m_aval[i] = 1'b0;
    foreach (m_vld[i])  if (i >= ts + 2 + RD_LAT) m_vld[i] = 4'h0;
    for (int p = 0; p < NP; p++) if (en[p]) ks.push_back(p);
    k = ks.size();
    if (k == 0) begin
      m_done[ts+1] = 1'b1;
    end else begin
      for (int i = 0; i < k; i++) begin
        a = addrs[ks[i]*16 +: 16];
        m_addr[ts+1+i] = a;
        m_aval[ts+1+i] = 1'b1;
        c = ts + 2 + RD_LAT + i;
        if (!m_vld.exists(c)) begin m_vld[c] = 4'h0; m_pd[c] = '0; end
        m_vld[c] = m_vld[c] | (4'h1 << ks[i]);
        pd = m_pd[c];
        pd[ks[i]*8 +: 8] = rom_fn(a);
        m_pd[c] = pd;
      end
      for (int i = ts + 1; i <= ts + RD_LAT + k; i++) m_busy[i] = 1'b1;
      m_done[ts+1+RD_LAT+k] = 1'b1;
    end
  endtask

  logic [3:0]  mv;
  logic [31:0] mpd;
  always @(negedge clk) begin
    if (mon_on) begin
      mv = 4'h0;
      if (m_vld.exists(cyc)) begin
        mv = m_vld[cyc];
        mpd = m_pd[cyc];
        for (int p = 0; p < NP; p++) if (mv[p]) ref_pd[p*8 +: 8] = mpd[p*8 +: 8];
      end
      chk("port_vld", port_vld, mv);
      chk("port_data", port_data, ref_pd);
      chk("done", done, (m_done.exists(cyc) && m_done[cyc]));
      chk("busy", busy, busy_at(cyc));
      chk("overrun", overrun, cyc >= m_ov_cyc);
      if (m_aval.exists(cyc) && m_aval[cyc]) chk("mem_addr", mem_addr, m_addr[cyc]);
    end
  end

  // Called at posedge+1; returns at posedge+1 after done (or budget expiry).
  task automatic run_window(input logic [3:0] en, input logic [63:0] addrs, input int budget,
                            output int done_off, output logic [3:0] pulsed, output bit saw_busy);
    int ts;
    port_en = en; port_addr = addrs; start = 1'b1; ts = cyc;
    model_start(ts, en, addrs);
    @(posedge clk); #1;
    start = 1'b0; port_en = 4'($urandom); port_addr = {$urandom, $urandom};
    done_off = -1; pulsed = '0; saw_busy = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      pulsed |= port_vld;
      saw_busy |= busy;
      if (done) begin done_off = cyc - ts; break; end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [63:0] addrs;
    int          done_off;
    logic [31:0] pd;
    logic [3:0]  pulsed;
    bit          busy;
  } vec_t;

  vec_t tbl[4];
  int d_off, ts, ndone, gap;
  logic [3:0] pul;
  bit sb;

  initial begin
    start = 1'b0; port_en = '0; port_addr = '0; reset_n = 1'b1; mon_on = 1'b0;
`ifdef IECDRV_ROMSHARE_WR_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_port_data", port_data, 0);
    chk("rst_port_vld", port_vld, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    tbl[0] = '{4'hF, 64'h3000_2000_1000_0000, 6, 32'h6A7A4A5A, 4'hF, 1'b1};
    tbl[1] = '{4'hA, 64'h7700_1100_4400_1100, 4, 32'h2D7A1E5A, 4'hA, 1'b1};
    tbl[2] = '{4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 32'h2D7A1E5A, 4'h0, 1'b0};
    tbl[3] = '{4'h1, 64'h0000_0000_0000_FF00, 3, 32'h2D7A1EA5, 4'h1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_window(tbl[i].en, tbl[i].addrs, 40, d_off, pul, sb);
      chk("tbl_done_latency", d_off, tbl[i].done_off);
      chk("tbl_port_data", port_data, tbl[i].pd);
      chk("tbl_pulsed_ports", pul, tbl[i].pulsed);
      chk("tbl_busy_seen", sb, tbl[i].busy);
    end

    // Start in the same cycle as done: fresh window, no overrun
    port_en = 4'hF; port_addr = 64'h0123_4567_89AB_CDEF; start = 1'b1; ts = cyc;
    model_start(ts, port_en, port_addr);
    @(posedge clk); #1; start = 1'b0;
    d_off = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin d_off = cyc - ts; break; end
    end
    chk("b2b_first_done", d_off, 6);
    port_en = 4'h6; port_addr = 64'hAAAA_5555_3C3C_C3C3; start = 1'b1; ts = cyc;
    model_start(ts, port_en, port_addr);
    @(posedge clk); #1; start = 1'b0;
    d_off = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin d_off = cyc - ts; break; end
    end
    chk("b2b_second_done", d_off, 4);
    chk("b2b_no_overrun", overrun, 0);
    @(posedge clk); #1;

    // Restart two cycles into a window
    port_en = 4'hF; port_addr = 64'h1100_2200_3300_4400; start = 1'b1; ts = cyc;
    model_start(ts, port_en, port_addr);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    port_en = 4'hF; port_addr = 64'hE000_D000_C000_B000; start = 1'b1; ts = cyc;
    model_start(ts, port_en, port_addr);
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ovr_done_count", ndone, 1);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_port_data", port_data, {rom_fn(16'hE000), rom_fn(16'hD000), rom_fn(16'hC000), rom_fn(16'hB000)});
    @(posedge clk); #1;

    // Reset in the middle of issuing
    port_en = 4'hF; port_addr = 64'h3000_2000_1000_0000; start = 1'b1; ts = cyc;
    model_start(ts, port_en, port_addr);
    @(posedge clk); #1; start = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_port_data", port_data, 0);
    chk("mid_rst_port_vld", port_vld, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_window(4'hF, 64'h3000_2000_1000_0000, 40, d_off, pul, sb);
    chk("post_rst_done", d_off, 6);
    chk("post_rst_data", port_data, 32'h6A7A4A5A);
    chk("post_rst_overrun", overrun, 0);

    // Random windows with random spacing, including overlapping starts
    for (int w = 0; w < 80; w++) begin
      port_en = 4'($urandom); port_addr = {$urandom, $urandom}; start = 1'b1; ts = cyc;
      model_start(ts, port_en, port_addr);
      @(posedge clk); #1;
      start = 1'b0; port_en = 4'($urandom); port_addr = {$urandom, $urandom};
      gap = $urandom_range(0, 11);
      repeat (gap) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;

`ifdef IECDRV_ROMSHARE_WR_EN
    mon_on = 1'b0;
    port_en = 4'hF; port_addr = 64'h3000_2000_1000_0000; start = 1'b1; ts = cyc;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 16'h2000; wr_data = 8'hC3;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, 8'hC3);
    chk("wr_mem_addr", mem_addr, 16'h2000);
    d_off = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin d_off = cyc - ts; break; end
    end
    chk("wr_done_latency", d_off, 7);
    @(posedge clk); #1;
    run_window(4'h4, 64'h0000_2000_0000_0000, 40, d_off, pul, sb);
    chk("wr_readback", port_data[23:16], 8'hC3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
